// File: rtl/norm_mult_seq.sv
// norm_mult_seq: approximate unsigned multiplier with sequential normalization.
// Each operand is shifted left until its MSB is set. The top M bits of each
// are multiplied by shift-add, and the product is shifted back right by the
// total normalization distance. The result is exact when both operands have
// at most M significant bits.
module norm_mult_seq #(
    parameter int unsigned W = 16,
    parameter int unsigned M = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result
);

    localparam int unsigned RW  = 2 * W;
    localparam int unsigned PW  = 2 * M;
    localparam int unsigned KW  = $clog2(W);
    localparam int unsigned CW  = $clog2(2 * W);
    localparam int unsigned NW  = $clog2(M);

    typedef enum logic [2:0] {
        IDLE,
        NORM_A,
        NORM_B,
        MUL,
        DENORM,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    logic [KW-1:0]   ka_q, ka_d;
    logic [KW-1:0]   kb_q, kb_d;
    logic [PW-1:0]   maq_q, maq_d;
    logic [M-1:0]    mq_q, mq_d;
    logic [PW-1:0]   p_q, p_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;
    logic [RW-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state and datapath: one normalization shift, one multiplier bit,
    // or one denormalization shift per cycle, depending on the state.
    always_comb begin
        logic [PW-1:0] p_nxt;
        p_nxt    = '0;
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ka_d     = ka_q;
        kb_d     = kb_q;
        maq_d    = maq_q;
        mq_d     = mq_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        c_d      = c_q;
        result_d = result_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (a == '0 || b == '0) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        sa_d    = a;
                        sb_d    = b;
                        ka_d    = '0;
                        kb_d    = '0;
                        state_d = NORM_A;
                    end
                end
            end
            NORM_A: begin
                if (!sa_q[W-1]) begin
                    sa_d = sa_q << 1;
                    ka_d = ka_q + 1'b1;
                end else begin
                    state_d = NORM_B;
                end
            end
            NORM_B: begin
                if (!sb_q[W-1]) begin
                    sb_d = sb_q << 1;
                    kb_d = kb_q + 1'b1;
                end else begin
                    // Both operands are normalized, so the mantissas are taken here.
                    maq_d   = PW'(sa_q[W-1 -: M]);
                    mq_d    = sb_q[W-1 -: M];
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                p_nxt = p_q + (mq_q[0] ? maq_q : '0);
                p_d   = p_nxt;
                maq_d = maq_q << 1;
                mq_d  = mq_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == NW'(M - 1)) begin
                    r_d     = RW'(p_nxt) << (RW - PW);
                    c_d     = CW'(ka_q) + CW'(kb_q);
                    state_d = DENORM;
                end
            end
            DENORM: begin
                if (c_q != '0) begin
                    r_d = r_q >> 1;
                    c_d = c_q - 1'b1;
                end else begin
                    result_d = r_q;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == NORM_A) || (state_d == NORM_B) ||
                 (state_d == MUL)    || (state_d == DENORM);
        done_d = (state_d == DONE);
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            ka_q     <= '0;
            kb_q     <= '0;
            maq_q    <= '0;
            mq_q     <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            r_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ka_q     <= ka_d;
            kb_q     <= kb_d;
            maq_q    <= maq_d;
            mq_q     <= mq_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            c_q      <= c_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
